// File: rtl/mips_pkg.sv
// Shared pipeline definitions: NOP encoding, reset PC, HALT opcode and the
// fetch-stage FSM state encodings.
package mips_pkg;

    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [31:0] PC_RESET    = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        IF_RUN    = 2'd0,
        IF_DRAIN  = 2'd1,
        IF_HALTED = 2'd2
    } if_state_t;

endpackage

// File: rtl/instr_rom.sv
// Instruction ROM: word-addressed, asynchronous read. Contents are loaded
// externally into mem.
module instr_rom #(
    parameter int    IMEM_ADDR_W    = 10,
    parameter string IMEM_INIT_FILE = "imem.hex"
) (
    input  logic [IMEM_ADDR_W-1:0] addr,
    output logic [31:0]            data
);

    logic [31:0] mem [0:(1<<IMEM_ADDR_W)-1];

    assign data = mem[addr];

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC register, ROM lookup, IF/ID register and the
// halt-drain FSM. A fetched HALT is held in IF/ID while the downstream stages
// drain; after DRAIN_CYCLES unstalled edges the stage reports halted.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IF_RUN    | normal fetch, PC advances by 4 per unstalled edge
//   IF_DRAIN  | HALT issued, PC frozen, feeding NOPs while the pipe drains
//   IF_HALTED | pipeline empty, everything frozen until reset
module stage_if
    import mips_pkg::*;
#(
    parameter int          IMEM_ADDR_W    = 10,
    parameter string       IMEM_INIT_FILE = "imem.hex",
    parameter logic [5:0]  HALT_OPCODE    = mips_pkg::HALT_OPCODE,
    parameter int          DRAIN_CYCLES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        pcSrc,
    input  logic [31:0] branchTarget,
    output logic [31:0] instr,
    output logic [31:0] pc_id,
    output logic [31:0] pc_if,
    output logic        draining,
    output logic        halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

    if_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      pc_next, instr_next, pc_id_next, pc_plus4, rom_data;

    instr_rom #(
        .IMEM_ADDR_W    (IMEM_ADDR_W),
        .IMEM_INIT_FILE (IMEM_INIT_FILE)
    ) u_rom (
        .addr (pc_if[IMEM_ADDR_W+1:2]),
        .data (rom_data)
    );

    // Next PC, IF/ID contents and FSM state; order of tests sets priority:
    // redirect, then stall, then drain countdown, then flush, then fetch.
    always_comb begin
        pc_next    = pc_if;
        instr_next = instr;
        pc_id_next = pc_id;
        state_next = state;
        cnt_next   = cnt;
        pc_plus4   = pc_if + 32'd4;

        if (state != IF_HALTED) begin
            if (pcSrc) begin
                // A redirect also cancels a speculative halt still draining.
                pc_next    = {branchTarget[31:2], 2'b00};
                instr_next = NOP;
                pc_id_next = 32'h0;
                state_next = IF_RUN;
                cnt_next   = '0;
            end else if (stall) begin
                if (flush) begin
                    instr_next = NOP;
                    pc_id_next = 32'h0;
                end
            end else if (state == IF_DRAIN) begin
                instr_next = NOP;
                pc_id_next = 32'h0;
                if (cnt == '0) state_next = IF_HALTED;
                else           cnt_next   = cnt - CNT_W'(1);
            end else if (flush) begin
                pc_next    = pc_plus4;
                instr_next = NOP;
                pc_id_next = 32'h0;
            end else if (rom_data[31:26] == HALT_OPCODE) begin
                // PC stays put so the HALT is not fetched a second time.
                instr_next = rom_data;
                pc_id_next = pc_plus4;
                state_next = IF_DRAIN;
                cnt_next   = CNT_INIT;
            end else begin
                pc_next    = pc_plus4;
                instr_next = rom_data;
                pc_id_next = pc_plus4;
            end
        end
    end

    // Registered PC, IF/ID and FSM state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_if <= PC_RESET;
            instr <= NOP;
            pc_id <= 32'h0;
            state <= IF_RUN;
            cnt   <= '0;
        end else begin
            pc_if <= pc_next;
            instr <= instr_next;
            pc_id <= pc_id_next;
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign draining = (state == IF_DRAIN);
    assign halted   = (state == IF_HALTED);

endmodule

// File: tb/tb_stage_if.sv
// Bench for the fetch stage: directed scenarios followed by random stimulus,
// all compared against a behavioural fetch model.
module tb_stage_if;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        pcSrc;
    logic [31:0] branchTarget;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic [31:0] pc_if;
    logic        draining;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom_img [0:1023];

    // Behavioural model state: drain_left counts edges still needed before halt.
    logic [31:0] m_pc, m_instr, m_pcid;
    int          m_drain_left;
    logic        m_halted;

    stage_if #(
        .IMEM_ADDR_W    (10),
        .IMEM_INIT_FILE ("")
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .pcSrc        (pcSrc),
        .branchTarget (branchTarget),
        .instr        (instr),
        .pc_id        (pc_id),
        .pc_if        (pc_if),
        .draining     (draining),
        .halted       (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_if"}, pc_if, m_pc);
        check({tag, ".instr"}, instr, m_instr);
        check({tag, ".pc_id"}, pc_id, m_pcid);
        check({tag, ".draining"}, 32'(draining), 32'(m_drain_left > 0));
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    endtask

    // One clock edge of the fetch stage, written from the behavioural rules.
    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic p, input logic [31:0] t);
        logic [31:0] word;
        if (r) begin
            m_pc = 0; m_instr = 0; m_pcid = 0; m_drain_left = 0; m_halted = 0;
            return;
        end
        if (m_halted) return;
        if (p) begin
            m_pc = {t[31:2], 2'b00}; m_instr = 0; m_pcid = 0; m_drain_left = 0;
            return;
        end
        if (s) begin
            if (f) begin m_instr = 0; m_pcid = 0; end
            return;
        end
        if (m_drain_left > 0) begin
            m_instr = 0; m_pcid = 0;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
            return;
        end
        if (f) begin
            m_pc = m_pc + 4; m_instr = 0; m_pcid = 0;
            return;
        end
        word = rom_img[m_pc[11:2]];
        m_instr = word;
        m_pcid  = m_pc + 4;
        if (word[31:26] == 6'h3f) m_drain_left = 4;
        else                      m_pc = m_pc + 4;
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic p,
                        input logic [31:0] t, input string tag);
        reset = r; stall = s; flush = f; pcSrc = p; branchTarget = t;
        model_edge(r, s, f, p, t);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, tag);
    endtask

    initial begin
        int          n;
        logic [31:0] w;
        logic        r, s, f, p;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; pcSrc = 1'b0; branchTarget = 32'h0;

        // ROM image: random non-HALT words, a sprinkling of HALTs past the
        // directed area, and fixed words for the directed scenarios.
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3f) w[31] = 1'b0;
            if (i >= 32 && i != 16 && $urandom_range(0, 63) == 0) w = 32'hFC00_0000 | (w & 32'h03FF_FFFF);
            rom_img[i] = w;
        end
        rom_img[0] = 32'h2001_0005;
        rom_img[1] = 32'h2002_0003;
        rom_img[2] = 32'h0022_1820;
        rom_img[3] = 32'h0000_0000;
        rom_img[5] = 32'hFC00_0000;
        for (int i = 0; i < 1024; i++) dut.u_rom.mem[i] = rom_img[i];

        // Reset and free run.
        step(1, 0, 0, 0, 32'h0, "t1_reset");
        check("t1_reset_pc", pc_if, 32'h0);
        check("t1_reset_instr", instr, 32'h0);
        check("t1_reset_halted", 32'(halted), 32'h0);
        step(0, 0, 0, 0, 32'h0, "t1_e1");
        check("t1_e1_instr", instr, 32'h2001_0005);
        check("t1_e1_pcid", pc_id, 32'd4);
        step(0, 0, 0, 0, 32'h0, "t1_e2");
        check("t1_e2_instr", instr, 32'h2002_0003);
        check("t1_e2_pcid", pc_id, 32'd8);
        step(0, 0, 0, 0, 32'h0, "t1_e3");
        check("t1_e3_instr", instr, 32'h0022_1820);
        check("t1_e3_pcid", pc_id, 32'd12);

        // Stall for two cycles at pc_if=8.
        step(1, 0, 0, 0, 32'h0, "t2_reset");
        run(2, "t2_run");
        step(0, 1, 0, 0, 32'h0, "t2_stall1");
        step(0, 1, 0, 0, 32'h0, "t2_stall2");
        check("t2_stall_pc", pc_if, 32'd8);
        check("t2_stall_instr", instr, 32'h2002_0003);
        step(0, 0, 0, 0, 32'h0, "t2_release");
        check("t2_release_instr", instr, 32'h0022_1820);
        check("t2_release_pcid", pc_id, 32'd12);

        // Redirect with misaligned target.
        step(0, 0, 0, 1, 32'h0000_0043, "t3_redirect");
        check("t3_redirect_pc", pc_if, 32'h40);
        check("t3_redirect_instr", instr, 32'h0);
        step(0, 0, 0, 0, 32'h0, "t3_after");
        check("t3_after_instr", instr, rom_img[16]);
        check("t3_after_pcid", pc_id, 32'h44);

        // Redirect wins over stall; stall plus flush squashes IF/ID only.
        step(0, 1, 0, 1, 32'h20, "t4_stall_redirect");
        check("t4_stall_redirect_pc", pc_if, 32'h20);
        step(0, 0, 0, 0, 32'h0, "t4_fetch");
        step(0, 1, 1, 0, 32'h0, "t4_stall_flush");
        check("t4_stall_flush_pc", pc_if, 32'h24);
        check("t4_stall_flush_instr", instr, 32'h0);

        // Halt and drain.
        step(1, 0, 0, 0, 32'h0, "t5_reset");
        run(6, "t5_run");
        check("t5_halt_instr", instr, 32'hFC00_0000);
        check("t5_halt_pc", pc_if, 32'd20);
        check("t5_halt_draining", 32'(draining), 32'h1);
        run(3, "t5_drain");
        check("t5_drain3_halted", 32'(halted), 32'h0);
        run(1, "t5_drain4");
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_halted_pc", pc_if, 32'd20);
        step(0, 0, 0, 1, 32'h100, "t5_pcsrc_ignored");
        step(0, 1, 1, 1, 32'h200, "t5_all_ignored");
        check("t5_ignored_pc", pc_if, 32'd20);
        step(1, 0, 0, 0, 32'h0, "t5_reset_exit");
        check("t5_exit_halted", 32'(halted), 32'h0);
        check("t5_exit_pc", pc_if, 32'h0);

        // Redirect two edges into drain cancels the halt.
        step(1, 0, 0, 0, 32'h0, "t6_reset");
        run(6, "t6_run");
        run(2, "t6_drain");
        step(0, 0, 0, 1, 32'h8, "t6_redirect");
        check("t6_redirect_draining", 32'(draining), 32'h0);
        check("t6_redirect_pc", pc_if, 32'h8);
        run(2, "t6_after");
        check("t6_after_halted", 32'(halted), 32'h0);

        // Stalls inside drain delay the halt by their count.
        step(1, 0, 0, 0, 32'h0, "t6b_reset");
        run(6, "t6b_run");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, "t6b_stall");
        n = 3;
        while (!halted && n < 20) begin
            step(0, 0, 0, 0, 32'h0, "t6b_drain");
            n++;
        end
        check("t6b_halt_edges", 32'(n), 32'd7);

        // Random stimulus against the model.
        step(1, 0, 0, 0, 32'h0, "rnd_reset");
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 9) == 0);
            step(r, s, f, p, $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
